// File: rtl/dsp_mac_pkg.sv
// Shared constants for the handshaked DSP MAC pipeline: OPMODE bit positions,
// default widths and saturation limits.
package dsp_mac_pkg;

  localparam int unsigned DEF_A_W = 18;
  localparam int unsigned DEF_B_W = 18;
  localparam int unsigned DEF_P_W = 48;
  localparam int unsigned MAX_P_W = 64;
  localparam int unsigned OP_W    = 4;

  localparam int unsigned OP_PRESUB  = 0;
  localparam int unsigned OP_PREADD  = 1;
  localparam int unsigned OP_POSTSUB = 2;
  localparam int unsigned OP_ACC     = 3;

  // Largest positive two's-complement value of width w (truncate at the call site).
  function automatic logic [MAX_P_W-1:0] sat_max(input int unsigned w);
    return (MAX_P_W'(1) << (w - 1)) - MAX_P_W'(1);
  endfunction

  // Most negative two's-complement value of width w (truncate at the call site).
  function automatic logic [MAX_P_W-1:0] sat_min(input int unsigned w);
    return MAX_P_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/dsp_mac_pipe_if.sv
// Input and output stream signals of the MAC pipeline; slave is the MAC side.
interface dsp_mac_pipe_if import dsp_mac_pkg::*; #(
  parameter int unsigned A_W = DEF_A_W,
  parameter int unsigned B_W = DEF_B_W,
  parameter int unsigned P_W = DEF_P_W
);

  logic            in_valid;
  logic            in_ready;
  logic [A_W-1:0]  a;
  logic [B_W-1:0]  b;
  logic [B_W-1:0]  d;
  logic [P_W-1:0]  c;
  logic            carryin;
  logic [OP_W-1:0] opmode;
  logic            last;
  logic            out_valid;
  logic            out_ready;
  logic [P_W-1:0]  p;
  logic            carryout;
  logic            ovf;

  modport slave (
    input  in_valid, a, b, d, c, carryin, opmode, last, out_ready,
    output in_ready, out_valid, p, carryout, ovf
  );

  modport master (
    output in_valid, a, b, d, c, carryin, opmode, last, out_ready,
    input  in_ready, out_valid, p, carryout, ovf
  );

endinterface

// File: rtl/dsp_mac_preadd_mult.sv
// First two pipeline stages: registered pre-adder, then signed multiply,
// with the post-add controls carried alongside. All stages advance on en.
module dsp_mac_preadd_mult import dsp_mac_pkg::*; #(
  parameter int unsigned A_W = DEF_A_W,
  parameter int unsigned B_W = DEF_B_W,
  parameter int unsigned P_W = DEF_P_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_fire,
  input  logic [A_W-1:0]  a,
  input  logic [B_W-1:0]  b,
  input  logic [B_W-1:0]  d,
  input  logic [P_W-1:0]  c,
  input  logic            carryin,
  input  logic [OP_W-1:0] opmode,
  input  logic            last,
  output logic            v2,
  output logic [P_W-1:0]  m2,
  output logic [P_W-1:0]  c2,
  output logic            cin2,
  output logic            post_sub2,
  output logic            acc_mode2,
  output logic            last2
);

  logic signed [B_W:0]   b_x;
  logic signed [B_W:0]   d_x;
  logic signed [B_W:0]   pre_c;

  logic                  v1;
  logic signed [A_W-1:0] a1;
  logic signed [B_W:0]   pre1;
  logic [P_W-1:0]        c1;
  logic                  cin1;
  logic                  post_sub1;
  logic                  acc_mode1;
  logic                  last1;

  // Pre-adder: one extra bit so D+B / D-B never wraps.
  always_comb begin
    b_x   = {b[B_W-1], b};
    d_x   = {d[B_W-1], d};
    pre_c = b_x;
    if (opmode[OP_PREADD]) begin
      pre_c = opmode[OP_PRESUB] ? (d_x - b_x) : (d_x + b_x);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      a1        <= '0;
      pre1      <= '0;
      c1        <= '0;
      cin1      <= 1'b0;
      post_sub1 <= 1'b0;
      acc_mode1 <= 1'b0;
      last1     <= 1'b0;
      v2        <= 1'b0;
      m2        <= '0;
      c2        <= '0;
      cin2      <= 1'b0;
      post_sub2 <= 1'b0;
      acc_mode2 <= 1'b0;
      last2     <= 1'b0;
    end else if (en) begin
      v1        <= in_fire;
      a1        <= a;
      pre1      <= pre_c;
      c1        <= c;
      cin1      <= carryin;
      post_sub1 <= opmode[OP_POSTSUB];
      acc_mode1 <= opmode[OP_ACC];
      last1     <= last;
      // Product fits in A_W+B_W+1 bits, so computing it at P_W is exact.
      v2        <= v1;
      m2        <= P_W'(a1) * P_W'(pre1);
      c2        <= c1;
      cin2      <= cin1;
      post_sub2 <= post_sub1;
      acc_mode2 <= acc_mode1;
      last2     <= last1;
    end
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Handshaked pre-add/multiply/post-add MAC with LAST-framed accumulation and
// sticky overflow. Define DSP_MAC_SATURATE_EN to clamp P/ACC on overflow.
module dsp_mac_pipe import dsp_mac_pkg::*; #(
  parameter int unsigned A_W = DEF_A_W,
  parameter int unsigned B_W = DEF_B_W,
  parameter int unsigned P_W = DEF_P_W
) (
  input  logic           clk,
  input  logic           rst,
  dsp_mac_pipe_if.slave  bus
);

  logic           en;
  logic           v2;
  logic [P_W-1:0] m2;
  logic [P_W-1:0] c2;
  logic           cin2;
  logic           post_sub2;
  logic           acc_mode2;
  logic           last2;
  logic           emit;

  logic [P_W-1:0] z;
  logic [P_W-1:0] madd;
  logic [P_W-1:0] mo;
  logic [P_W:0]   r;
  logic [P_W-1:0] rs;
  logic           ovf_c;

  logic [P_W-1:0] p_q;
  logic           co_q;
  logic           ovf_q;
  logic           ov_q;
  logic [P_W-1:0] acc;
  logic           first;
  logic           ovf_acc;

  // Whole pipe stalls only when a result is held and the consumer is not taking it.
  assign en            = ~ov_q | bus.out_ready;
  assign bus.in_ready  = en & ~rst;
  assign bus.out_valid = ov_q;
  assign bus.p         = p_q;
  assign bus.carryout  = co_q;
  assign bus.ovf       = ovf_q;
  assign emit          = v2 & (~acc_mode2 | last2);

  dsp_mac_preadd_mult #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) u_pm (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_fire   (bus.in_valid & bus.in_ready),
    .a         (bus.a),
    .b         (bus.b),
    .d         (bus.d),
    .c         (bus.c),
    .carryin   (bus.carryin),
    .opmode    (bus.opmode),
    .last      (bus.last),
    .v2        (v2),
    .m2        (m2),
    .c2        (c2),
    .cin2      (cin2),
    .post_sub2 (post_sub2),
    .acc_mode2 (acc_mode2),
    .last2     (last2)
  );

  // Post-adder at P_W+1 bits; mo is the effective signed addend for overflow.
  always_comb begin
    z     = c2;
    madd  = m2 + P_W'(cin2);
    mo    = madd;
    r     = {1'b0, z} + {1'b0, m2} + (P_W+1)'(cin2);
    if (acc_mode2) begin
      z = first ? '0 : acc;
    end
    if (post_sub2) begin
      r  = {1'b0, z} - ({1'b0, m2} + (P_W+1)'(cin2));
      mo = -madd;
    end else begin
      r  = {1'b0, z} + {1'b0, m2} + (P_W+1)'(cin2);
    end
    ovf_c = (z[P_W-1] == mo[P_W-1]) && (r[P_W-1] != z[P_W-1]);
    rs    = r[P_W-1:0];
`ifdef DSP_MAC_SATURATE_EN
    if (ovf_c) begin
      rs = z[P_W-1] ? P_W'(sat_min(P_W)) : P_W'(sat_max(P_W));
    end
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
      acc     <= '0;
      first   <= 1'b1;
      ovf_acc <= 1'b0;
    end else if (en) begin
      ov_q <= emit;
      if (v2) begin
        if (acc_mode2) begin
          acc <= rs;
          if (last2) begin
            first   <= 1'b1;
            ovf_acc <= 1'b0;
          end else begin
            first   <= 1'b0;
            ovf_acc <= ovf_acc | ovf_c;
          end
        end else begin
          first   <= 1'b1;
          ovf_acc <= 1'b0;
        end
        if (emit) begin
          p_q   <= rs;
          co_q  <= r[P_W];
          ovf_q <= ovf_c | (acc_mode2 & ovf_acc);
        end
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed plus randomized scoreboard bench for dsp_mac_pipe; expected results
// come from a wide-integer reference model evaluated at beat acceptance.
module tb_dsp_mac_pipe;

  localparam int unsigned A_W = 18;
  localparam int unsigned B_W = 18;
  localparam int unsigned P_W = 48;
  localparam longint PMAX = 64'sh0000_7FFF_FFFF_FFFF;
  localparam longint PMIN = -PMAX - 64'sd1;
  localparam logic [63:0] MASK = 64'h0000_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [P_W-1:0] p;
    logic           co;
    logic           ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   out_count;
  exp_t q[$];

  longint m_acc;
  logic   m_first;
  logic   m_sticky;

  dsp_mac_pipe_if #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) bus ();

  dsp_mac_pipe #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc    = 0;
    m_first  = 1'b1;
    m_sticky = 1'b0;
  endtask

  // Reference: exact arithmetic in 64 bits, overflow by range test.
  task automatic model_accept(input longint a, input longint b, input longint d, input longint c,
                              input logic cin, input logic [3:0] op, input logic last);
    longint pre, m, z, t, res;
    logic ov, co;
    logic [63:0] zu, mu, s;
    exp_t e;
    pre = op[1] ? (op[0] ? d - b : d + b) : b;
    m   = a * pre;
    z   = op[3] ? (m_first ? 64'sd0 : m_acc) : c;
    t   = op[2] ? z - (m + longint'(cin)) : z + m + longint'(cin);
    ov  = (t > PMAX) || (t < PMIN);
    res = t;
    if (ov) begin
`ifdef DSP_MAC_SATURATE_EN
      res = (t > PMAX) ? PMAX : PMIN;
`else
      res = (t <<< 16) >>> 16;
`endif
    end
    zu = 64'(z) & MASK;
    mu = 64'(m) & MASK;
    s  = op[2] ? zu - (mu + 64'(cin)) : zu + mu + 64'(cin);
    co = s[48];
    if (op[3]) begin
      m_acc = res;
      if (last) begin
        e = '{p: P_W'(res), co: co, ovf: m_sticky | ov};
        q.push_back(e);
        m_sticky = 1'b0;
        m_first  = 1'b1;
      end else begin
        m_sticky = m_sticky | ov;
        m_first  = 1'b0;
      end
    end else begin
      e = '{p: P_W'(res), co: co, ovf: ov};
      q.push_back(e);
      m_sticky = 1'b0;
      m_first  = 1'b1;
    end
  endtask

  task automatic send(input longint a, input longint b, input longint d, input longint c,
                      input logic cin, input logic [3:0] op, input logic last);
    bit ok;
    ok = 1'b0;
    bus.a        = A_W'(a);
    bus.b        = B_W'(b);
    bus.d        = B_W'(d);
    bus.c        = P_W'(c);
    bus.carryin  = cin;
    bus.opmode   = op;
    bus.last     = last;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        model_accept(a, b, d, c, cin, op, last);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Returns at the negedge where out_valid is seen; n counts negedges waited.
  task automatic wait_out(output int n);
    n = 0;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        n = t;
        break;
      end
    end
    if (n == 0) check("wait_out_timeout", 64'(n), 64'd1);
  endtask

  function automatic longint rnd_s(input int unsigned w);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return longint'(r << (64 - w)) >>> (64 - w);
  endfunction

  // Scoreboard side: every handshaken result must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      out_count++;
      n_cmp++;
      assert (q.size() > 0) else begin
        n_err++;
        $error("FAIL sb_underflow observed=%0h expected=queued result", bus.p);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb_p", 64'(bus.p), 64'(e.p));
        check("sb_carryout", 64'(bus.carryout), 64'(e.co));
        check("sb_ovf", 64'(bus.ovf), 64'(e.ovf));
      end
    end
  end

  initial begin
    int n;
    int c0;
    n_cmp = 0;
    n_err = 0;
    out_count = 0;
    model_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.d         = '0;
    bus.c         = '0;
    bus.carryin   = 1'b0;
    bus.opmode    = '0;
    bus.last      = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_p", 64'(bus.p), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    check("rst_carryout", 64'(bus.carryout), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Pre-add then multiply then add C, with latency measurement
    send(3, 4, 5, 10, 1'b0, 4'b0010, 1'b0);
    wait_out(n);
    check("latency", 64'(n), 64'd3);
    check("preadd_p", 64'(bus.p), 64'd37);
    @(posedge clk);
    #1;

    // Pre-subtract and post-subtract with carry: 100 - ((-7)*(-2-4) + 1) = 57
    send(-7, 4, -2, 100, 1'b1, 4'b0111, 1'b0);
    wait_out(n);
    check("postsub_p", 64'(bus.p), 64'd57);
    @(posedge clk);
    #1;

    // Accumulation packet of four beats, then the same again from zero
    for (int k = 0; k < 2; k++) begin
      c0 = out_count;
      for (int i = 0; i < 4; i++) send(2, 3, 0, 0, 1'b0, 4'b1000, i == 3);
      wait_out(n);
      check("acc_p", 64'(bus.p), 64'd24);
      @(posedge clk);
      repeat (5) @(posedge clk);
      #1;
      check("acc_one_output", 64'(out_count - c0), 64'd1);
    end

    // Non-accumulate stream with a five-cycle consumer stall mid-stream
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(rnd_s(A_W), rnd_s(B_W), rnd_s(B_W), rnd_s(P_W), 1'($urandom),
               {1'b0, 3'($urandom)}, 1'($urandom));
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", 64'(bus.in_ready), 64'd0);
          check("stall_out_valid", 64'(bus.out_valid), 64'd1);
          check("stall_p_held", 64'(bus.p), 64'(q[0].p));
          @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;

    // Positive overflow at the top of the P range
    send(1, 1, 0, PMAX, 1'b0, 4'b0000, 1'b0);
    wait_out(n);
    check("ovf_flag", 64'(bus.ovf), 64'd1);
`ifdef DSP_MAC_SATURATE_EN
    check("ovf_p", 64'(bus.p), 64'h0000_7FFF_FFFF_FFFF);
`else
    check("ovf_p", 64'(bus.p), 64'h0000_8000_0000_0000);
`endif
    @(posedge clk);
    #1;

    // Reset in the middle of a packet discards the partial sum
    c0 = out_count;
    send(2, 3, 0, 0, 1'b0, 4'b1000, 1'b0);
    send(2, 3, 0, 0, 1'b0, 4'b1000, 1'b0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_no_output", 64'(out_count - c0), 64'd0);
    send(1, 5, 0, 0, 1'b0, 4'b1000, 1'b0);
    send(1, 5, 0, 0, 1'b0, 4'b1000, 1'b1);
    wait_out(n);
    check("rst_mid_fresh_p", 64'(bus.p), 64'd10);
    @(posedge clk);
    #1;

    // Mixed random opmodes and packets under random backpressure
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          logic [3:0] op;
          logic       lst;
          op  = 4'($urandom);
          lst = ($urandom_range(0, 2) == 0);
          if (i == 15) begin
            op  = 4'b1000;
            lst = 1'b1;
          end
          send(rnd_s(A_W), rnd_s(B_W), rnd_s(B_W), rnd_s(P_W), 1'($urandom), op, lst);
        end
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1 bus.out_ready = 1'($urandom);
        end
        bus.out_ready = 1'b1;
      end
    join

    // Drain and confirm nothing is left outstanding
    for (int t = 0; t < 50 && q.size() > 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
